// File: rtl/nonce_job_scheduler.sv
`timescale 1ns/1ps
// Job scheduler for the 8-way nonce search core: queues host jobs,
// launches the core, holds job data steady and collects tagged results.
module nonce_job_scheduler #(
    parameter int unsigned JOB_DEPTH   = 2,
    parameter int unsigned RES_DEPTH   = 2,
    parameter logic [31:0] WDOG_CYCLES = 32'h2000_0100
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [95:0]  job_m_data,
    input  logic [255:0] job_initial_h,
    input  logic [3:0]   job_hash_id,
    input  logic [31:0]  job_dify,
    output logic         core_start,
    output logic [95:0]  core_m_data,
    output logic [255:0] core_initial_h,
    output logic [3:0]   core_hash_id,
    output logic [31:0]  core_dify,
    input  logic         core_busy,
    input  logic         core_success,
    input  logic [31:0]  core_nonce,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [37:0]  res_data,
    output logic         sched_running,
    output logic [15:0]  jobs_done
);

    localparam int unsigned JAW = $clog2(JOB_DEPTH);
    localparam int unsigned RAW = $clog2(RES_DEPTH);
    localparam int unsigned JPW = JAW + 1;
    localparam int unsigned RPW = RAW + 1;

    typedef struct packed {
        logic [95:0]  m_data;
        logic [255:0] initial_h;
        logic [3:0]   hash_id;
        logic [31:0]  dify;
    } job_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_RUN
    } state_e;

    state_e       state_q, state_d;
    logic [31:0]  wdog_q, wdog_d;
    logic         ready_q, ready_d;
    job_t         held_q, held_d;
    job_t         job_mem_q [JOB_DEPTH];
    job_t         job_mem_d [JOB_DEPTH];
    logic [JAW:0] job_wr_q, job_wr_d;
    logic [JAW:0] job_rd_q, job_rd_d;
    logic [37:0]  res_mem_q [RES_DEPTH];
    logic [37:0]  res_mem_d [RES_DEPTH];
    logic [RAW:0] res_wr_q, res_wr_d;
    logic [RAW:0] res_rd_q, res_rd_d;
    logic [15:0]  jobs_done_q, jobs_done_d;

    logic        job_empty, job_full, job_push, job_pop;
    logic        res_empty, res_full, res_push, res_pop;
    logic [37:0] res_word;

    assign job_empty = (job_wr_q == job_rd_q);
    assign job_full  = (job_wr_q[JAW] != job_rd_q[JAW]) &&
                       (job_wr_q[JAW-1:0] == job_rd_q[JAW-1:0]);
    assign res_empty = (res_wr_q == res_rd_q);
    assign res_full  = (res_wr_q[RAW] != res_rd_q[RAW]) &&
                       (res_wr_q[RAW-1:0] == res_rd_q[RAW-1:0]);

    assign job_ready = ready_q & ~job_full & ~flush;
    assign job_push  = job_valid & job_ready;
    assign res_valid = ~res_empty;
    assign res_pop   = res_ready & ~res_empty;
    assign res_data  = res_mem_q[res_rd_q[RAW-1:0]];

    assign core_start     = (state_q == S_LAUNCH);
    assign sched_running  = (state_q != S_IDLE);
    assign core_m_data    = held_q.m_data;
    assign core_initial_h = held_q.initial_h;
    assign core_hash_id   = held_q.hash_id;
    assign core_dify      = held_q.dify;
    assign jobs_done      = jobs_done_q;

    // Sequencing: pick a job, pulse start, settle, then watch the core.
    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        held_d   = held_q;
        job_pop  = 1'b0;
        res_push = 1'b0;
        res_word = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!job_empty && !res_full) begin
                    job_pop = 1'b1;
                    held_d  = job_mem_q[job_rd_q[JAW-1:0]];
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_ARM;
            S_ARM:    state_d = S_RUN;
            S_RUN: begin
                if (!core_busy) begin
                    res_push = 1'b1;
                    res_word = core_success ?
                               {held_q.hash_id, 2'b01, core_nonce} :
                               {held_q.hash_id, 2'b10, 32'h0};
                    wdog_d   = '0;
                    state_d  = S_IDLE;
                end else if (wdog_q == WDOG_CYCLES - 32'd1) begin
                    res_push = 1'b1;
                    res_word = {held_q.hash_id, 2'b11, 32'h0};
                    wdog_d   = '0;
                    state_d  = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            wdog_d   = '0;
            held_d   = held_q;
            job_pop  = 1'b0;
            res_push = 1'b0;
        end
    end

    // Queue pointers, storage and the completed-job counter.
    always_comb begin
        ready_d     = 1'b1;
        job_mem_d   = job_mem_q;
        job_wr_d    = job_wr_q + JPW'(job_push);
        job_rd_d    = job_rd_q + JPW'(job_pop);
        res_mem_d   = res_mem_q;
        res_wr_d    = res_wr_q + RPW'(res_push);
        res_rd_d    = res_rd_q + RPW'(res_pop);
        jobs_done_d = jobs_done_q + 16'(res_push);
        if (job_push) begin
            job_mem_d[job_wr_q[JAW-1:0]] =
                '{job_m_data, job_initial_h, job_hash_id, job_dify};
        end
        if (res_push) begin
            res_mem_d[res_wr_q[RAW-1:0]] = res_word;
        end
        if (flush) begin
            job_rd_d = job_wr_q;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wdog_q      <= '0;
            ready_q     <= 1'b0;
            held_q      <= '0;
            job_mem_q   <= '{default: '0};
            job_wr_q    <= '0;
            job_rd_q    <= '0;
            res_mem_q   <= '{default: '0};
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            ready_q     <= ready_d;
            held_q      <= held_d;
            job_mem_q   <= job_mem_d;
            job_wr_q    <= job_wr_d;
            job_rd_q    <= job_rd_d;
            res_mem_q   <= res_mem_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            jobs_done_q <= jobs_done_d;
        end
    end

endmodule

// File: tb/tb_nonce_job_scheduler.sv
`timescale 1ns/1ps
// Bench for nonce_job_scheduler: behavioural core model plus a
// job/result scoreboard, driven by directed and randomized steps.
module tb_nonce_job_scheduler;

    localparam int WD = 100;

    typedef struct packed {
        logic [95:0]  m;
        logic [255:0] h;
        logic [3:0]   id;
        logic [31:0]  d;
    } job_s;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [95:0]  job_m_data = '0;
    logic [255:0] job_initial_h = '0;
    logic [3:0]   job_hash_id = '0;
    logic [31:0]  job_dify = '0;
    logic         core_start;
    logic [95:0]  core_m_data;
    logic [255:0] core_initial_h;
    logic [3:0]   core_hash_id;
    logic [31:0]  core_dify;
    logic         core_busy;
    logic         core_success;
    logic [31:0]  core_nonce;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [37:0]  res_data;
    logic         sched_running;
    logic [15:0]  jobs_done;

    always #5 clk = ~clk;

    nonce_job_scheduler #(
        .JOB_DEPTH  (2),
        .RES_DEPTH  (2),
        .WDOG_CYCLES(32'd100)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_m_data    (job_m_data),
        .job_initial_h (job_initial_h),
        .job_hash_id   (job_hash_id),
        .job_dify      (job_dify),
        .core_start    (core_start),
        .core_m_data   (core_m_data),
        .core_initial_h(core_initial_h),
        .core_hash_id  (core_hash_id),
        .core_dify     (core_dify),
        .core_busy     (core_busy),
        .core_success  (core_success),
        .core_nonce    (core_nonce),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .sched_running (sched_running),
        .jobs_done     (jobs_done)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          starts = 0;
    int          popped = 0;
    int          exp_total = 0;
    int          start_cyc[$];
    job_s        mq[$];
    logic [37:0] eq[$];
    logic [37:0] last_pop = '0;
    bit          inflight = 0;
    bit          rr_rand = 0;
    bit          cfg_rand = 0;
    bit          cfg_succ = 0;
    bit          cfg_hang = 0;
    int          cfg_lat = 1;
    logic [31:0] cfg_nonce = '0;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: restarts on every start pulse and finishes after a
    // chosen latency, or never when hanging; also books expected results.
    initial begin
        int   rem;
        int   since;
        bit   hang_l;
        bit   succ_l;
        bit   clr_pend;
        logic [31:0] n_l;
        job_s jj;
        rem = 0; since = 0; hang_l = 0; succ_l = 0; clr_pend = 0; n_l = '0;
        core_busy = 1'b0; core_success = 1'b0; core_nonce = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            since++;
            if (clr_pend) begin inflight = 0; clr_pend = 0; end
            if (inflight && hang_l && since == WD + 2) inflight = 0;
            if (core_start) begin
                starts++;
                start_cyc.push_back(cyc);
                since = 0;
                if (cfg_rand) begin
                    succ_l = 1'($urandom_range(0, 1));
                    hang_l = 0;
                    rem    = $urandom_range(1, 6);
                    n_l    = $urandom;
                end else begin
                    succ_l = cfg_succ;
                    hang_l = cfg_hang;
                    rem    = cfg_lat;
                    n_l    = cfg_nonce;
                end
                check("launch_has_job", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    jj = mq.pop_front();
                    check("core_m_data", core_m_data, jj.m);
                    check("core_initial_h", core_initial_h, jj.h);
                    check("core_hash_id", core_hash_id, jj.id);
                    check("core_dify", core_dify, jj.d);
                    if (hang_l)      eq.push_back({jj.id, 2'b11, 32'h0});
                    else if (succ_l) eq.push_back({jj.id, 2'b01, n_l});
                    else             eq.push_back({jj.id, 2'b10, 32'h0});
                    inflight = 1;
                    exp_total++;
                end
                core_busy = 1'b1;
                core_success = 1'b0;
                core_nonce = $urandom;
            end else if (core_busy && !hang_l) begin
                if (rem == 0) begin
                    core_busy = 1'b0;
                    core_success = succ_l;
                    core_nonce = succ_l ? n_l : $urandom;
                    clr_pend = 1;
                end else begin
                    rem--;
                end
            end else if (!core_busy) begin
                core_success = 1'b0;
            end
        end
    end

    // Result monitor: every pop must match the oldest expected result.
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && res_valid && res_ready) begin
                popped++;
                last_pop = res_data;
                check("res_expected_avail", eq.size() > 0, 1);
                if (eq.size() > 0) begin
                    e = eq.pop_front();
                    check("res_data", res_data, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    function automatic job_s mkjob(input logic [3:0] id);
        job_s j;
        j.m  = {$urandom, $urandom, $urandom};
        for (int k = 0; k < 8; k++) j.h[k*32 +: 32] = $urandom;
        j.id = id;
        j.d  = $urandom;
        return j;
    endfunction

    task automatic send(input job_s j);
        bit acc;
        acc = 0;
        job_valid = 1'b1;
        job_m_data = j.m;
        job_initial_h = j.h;
        job_hash_id = j.id;
        job_dify = j.d;
        for (int i = 0; i < 400 && !acc; i++) begin
            if (job_ready) begin acc = 1; mq.push_back(j); end
            if (rr_rand) res_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        job_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    task automatic wait_popped(input int target, input int budget);
        for (int i = 0; i < budget && popped < target; i++) tick(1);
        check("drain_count", popped, target);
    endtask

    initial begin
        int   s0;
        int   p0;
        int   jd0;
        bit   seen;
        logic [31:0] nn;

        // Reset state
        tick(3);
        check("rst_running", sched_running, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_core_start", core_start, 0);
        check("rst_job_ready", job_ready, 0);
        reset_n = 1'b1;
        #1 check("ready_at_release", job_ready, 0);
        tick(1);
        check("ready_after_release", job_ready, 1);

        // Found nonce
        cfg_succ = 1; cfg_hang = 0; cfg_lat = $urandom_range(1, 8);
        cfg_nonce = 32'h1234_5678;
        res_ready = 1'b1;
        send(mkjob(4'h3));
        wait_popped(1, 60);
        check("found_word", last_pop, {4'h3, 2'b01, 32'h1234_5678});
        check("found_jobs_done", jobs_done, 1);
        check("found_starts", starts, 1);

        // Exhausted
        cfg_succ = 0;
        send(mkjob(4'hA));
        wait_popped(2, 60);
        check("exh_word", last_pop, {4'hA, 2'b10, 32'h0});
        check("exh_starts", starts, 2);
        check("exh_jobs_done", jobs_done, 2);

        // Watchdog timeout then relaunch
        res_ready = 1'b0;
        cfg_hang = 1;
        send(mkjob(4'h5));
        seen = 0;
        for (int i = 0; i < WD + 30 && !seen; i++) begin
            if (res_valid) seen = 1; else tick(1);
        end
        check("tmo_seen", seen, 1);
        check("tmo_cycle", cyc - start_cyc[start_cyc.size()-1], WD + 2);
        cfg_hang = 0; cfg_succ = 1; nn = $urandom; cfg_nonce = nn;
        send(mkjob(4'h6));
        res_ready = 1'b1;
        wait_popped(4, 80);
        check("relaunch_word", last_pop, {4'h6, 2'b01, nn});
        check("relaunch_starts", starts, 4);

        // Result FIFO full holds the third job
        res_ready = 1'b0;
        cfg_lat = 2;
        s0 = starts; p0 = popped;
        for (int k = 0; k < 3; k++) send(mkjob(4'(k + 8)));
        tick(40);
        check("resfull_starts", starts - s0, 2);
        check("resfull_idle", sched_running, 0);
        check("resfull_valid", res_valid, 1);
        check("b2b_gap", start_cyc[s0+1] - start_cyc[s0], 5);
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        tick(20);
        check("resfull_third", starts - s0, 3);
        res_ready = 1'b1;
        wait_popped(p0 + 3, 60);

        // Flush during RUN with one queued job
        cfg_hang = 1;
        s0 = starts; jd0 = jobs_done;
        send(mkjob(4'h1));
        tick(2);
        cfg_hang = 0;
        send(mkjob(4'h2));
        tick(8);
        check("flush_pre_running", sched_running, 1);
        flush = 1'b1;
        job_valid = 1'b1;
        #1 check("flush_ready", job_ready, 0);
        if (inflight) begin
            void'(eq.pop_back());
            inflight = 0;
            exp_total--;
        end
        mq.delete();
        tick(1);
        flush = 1'b0;
        job_valid = 1'b0;
        check("flush_idle", sched_running, 0);
        tick(20);
        check("flush_no_launch", starts - s0, 1);
        check("flush_no_result", jobs_done, jd0);
        check("flush_res_empty", res_valid, 0);

        // Job queue full
        cfg_hang = 1;
        s0 = starts; p0 = popped;
        send(mkjob(4'h4));
        tick(3);
        cfg_hang = 0; cfg_succ = 1; cfg_lat = 1;
        send(mkjob(4'h7));
        send(mkjob(4'hB));
        job_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("qfull_ready", job_ready, 0);
            tick(1);
        end
        send(mkjob(4'hC));
        check("qfull_accept_after_pop", starts - s0, 2);
        wait_popped(p0 + 4, 300);

        // Randomized traffic
        cfg_rand = 1;
        rr_rand = 1;
        p0 = popped;
        for (int k = 0; k < 24; k++) begin
            send(mkjob(4'($urandom)));
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                res_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
        end
        rr_rand = 0;
        res_ready = 1'b1;
        wait_popped(p0 + 24, 600);
        check("rand_jobs_done", jobs_done, 16'(exp_total));

        // Reset mid-RUN
        cfg_rand = 0;
        cfg_hang = 1;
        send(mkjob(4'hE));
        tick(5);
        check("rstrun_running", sched_running, 1);
        reset_n = 1'b0;
        #1;
        eq.delete();
        mq.delete();
        inflight = 0;
        check("rstrun_idle", sched_running, 0);
        check("rstrun_start", core_start, 0);
        check("rstrun_res", res_valid, 0);
        check("rstrun_done", jobs_done, 0);
        check("rstrun_ready", job_ready, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("rstrun_ready_back", job_ready, 1);
        check("rstrun_stay_idle", sched_running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
